// File: rtl/cp0_exc_if.sv
// Memory-stage exception inputs, MTC0/MFC0 access and CP0 status outputs
// shared between the pipeline and the CP0 exception unit.
interface cp0_exc_if;
  logic        validM;
  logic [31:0] pcM;
  logic        in_dslotM;
  logic        adelM;
  logic        adesM;
  logic [31:0] data_addrM;
  logic        syscallM;
  logic        breakM;
  logic        eretM;
  logic        riM;
  logic        ovM;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] excepttype_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic [31:0] epc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic        timer_int_o;

  modport master (
    output validM, pcM, in_dslotM, adelM, adesM, data_addrM,
           syscallM, breakM, eretM, riM, ovM, int_i,
           we_i, waddr_i, wdata_i, raddr_i,
    input  rdata_o, excepttype_o, flush_o, newpc_o,
           epc_o, status_o, cause_o, timer_int_o
  );

  modport slave (
    input  validM, pcM, in_dslotM, adelM, adesM, data_addrM,
           syscallM, breakM, eretM, riM, ovM, int_i,
           we_i, waddr_i, wdata_i, raddr_i,
    output rdata_o, excepttype_o, flush_o, newpc_o,
           epc_o, status_o, cause_o, timer_int_o
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Memory-stage exception prioritiser and CP0 register file: BadVAddr, Count,
// Compare, Status, Cause, EPC, plus flush/redirect generation.
module cp0_exc_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
  input logic      clk,
  input logic      rst,
  cp0_exc_if.slave bus
);

  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  logic [31:0] badVAddr, count, compare, status, cause, epc;
  logic        timerInt, tick;

  logic [7:0]  ip;
  logic        intPend;
  logic [31:0] excType;
  logic [4:0]  excCode;
  logic        fetchErr, dataErr;
  logic        trap, isEret, eretEpcWr, wrOk;

  always_comb begin
    ip      = {timerInt | bus.int_i[5], bus.int_i[4:0], cause[9:8]};
    intPend = (|(ip & status[15:8])) & status[0] & ~status[1];
  end

  always_comb begin
    excType  = '0;
    excCode  = '0;
    fetchErr = 1'b0;
    dataErr  = 1'b0;
    if (bus.validM) begin
      if (intPend) begin
        excType = 32'h1;  excCode = 5'd0;
      end else if (bus.pcM[1:0] != 2'b00) begin
        excType = 32'h4;  excCode = 5'd4;  fetchErr = 1'b1;
      end else if (bus.riM) begin
        excType = 32'ha;  excCode = 5'd10;
      end else if (bus.syscallM) begin
        excType = 32'h8;  excCode = 5'd8;
      end else if (bus.breakM) begin
        excType = 32'h9;  excCode = 5'd9;
      end else if (bus.ovM) begin
        excType = 32'hc;  excCode = 5'd12;
      end else if (bus.adelM) begin
        excType = 32'h4;  excCode = 5'd4;  dataErr = 1'b1;
      end else if (bus.adesM) begin
        excType = 32'h5;  excCode = 5'd5;  dataErr = 1'b1;
      end else if (bus.eretM) begin
        excType = 32'he;
      end
    end
  end

  // Only an ERET may share its cycle with an MTC0, and only for the EPC bypass.
  always_comb begin
    isEret    = (excType == 32'he);
    trap      = (excType != 32'h0) && !isEret;
    eretEpcWr = bus.we_i && (bus.waddr_i == 5'd14);
    wrOk      = bus.we_i && ((excType == 32'h0) || (isEret && bus.waddr_i == 5'd14));
  end

  assign bus.excepttype_o = excType;
  assign bus.flush_o      = (excType != 32'h0);
  assign bus.newpc_o      = isEret ? (eretEpcWr ? bus.wdata_i : epc)
                                   : (trap ? EXC_VECTOR : 32'h0);
  assign bus.epc_o        = epc;
  assign bus.status_o     = status;
  assign bus.cause_o      = cause;
  assign bus.timer_int_o  = timerInt;

  always_comb begin
    case (bus.raddr_i)
      5'd8:    bus.rdata_o = badVAddr;
      5'd9:    bus.rdata_o = count;
      5'd11:   bus.rdata_o = compare;
      5'd12:   bus.rdata_o = status;
      5'd13:   bus.rdata_o = cause;
      5'd14:   bus.rdata_o = epc;
      5'd15:   bus.rdata_o = PRID_VAL;
      default: bus.rdata_o = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badVAddr <= '0;
      count    <= '0;
      compare  <= '0;
      status   <= STATUS_RST;
      cause    <= '0;
      epc      <= '0;
      timerInt <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wrOk && bus.waddr_i == 5'd9) begin
        count <= bus.wdata_i;
        tick  <= 1'b0;
      end else if (tick) begin
        count <= count + 32'd1;
      end

      // A Compare write clears the timer even if Count==Compare this cycle.
      if (wrOk && bus.waddr_i == 5'd11) begin
        compare  <= bus.wdata_i;
        timerInt <= 1'b0;
      end else if (count == compare && compare != 32'h0) begin
        timerInt <= 1'b1;
      end

      cause[15:10] <= ip[7:2];

      if (trap) begin
        status[1]  <= 1'b1;
        cause[6:2] <= excCode;
        cause[31]  <= bus.in_dslotM;
        epc        <= bus.in_dslotM ? bus.pcM - 32'd4 : bus.pcM;
        if (fetchErr)
          badVAddr <= bus.pcM;
        else if (dataErr)
          badVAddr <= bus.data_addrM;
      end else if (isEret) begin
        status[1] <= 1'b0;
      end

      if (wrOk) begin
        case (bus.waddr_i)
          5'd12:   status     <= (status & ~STATUS_MASK) | (bus.wdata_i & STATUS_MASK);
          5'd13:   cause[9:8] <= bus.wdata_i[9:8];
          5'd14:   epc        <= bus.wdata_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboarded bench for cp0_exc_unit: directed scenarios followed by random
// traffic, checked against a rule-level CP0 model.
module tb_cp0_exc_unit;

  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] PRID = 32'h004C0102;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_exc_if bus();

  cp0_exc_unit #(.EXC_VECTOR(VEC), .PRID_VAL(PRID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, validM, inDslot, adel, ades, sys, brk, eret, ri, ov, we;
    logic [31:0] pcM, dataAddr, wdata;
    logic [5:0]  intI;
    logic [4:0]  waddr, raddr;
  } stim_t;

  typedef struct {
    logic [31:0] exc, newpc, rdata, epc, status, cause;
    logic        flush, timer;
  } exp_t;

  // Priority table: pending int, fetch misalign, RI, SYS, BP, OV, AdEL, AdES, ERET
  int excEnc[9]  = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
  int excCode[9] = '{0, 4, 10, 8, 9, 12, 4, 5, 0};
  int wTab[8]    = '{8, 9, 11, 12, 13, 14, 3, 15};

  logic [31:0] mBad, mCount, mCompare, mStatus, mCause, mEpc;
  logic        mTimer, mTick;

  exp_t  expQ[$];
  stim_t cur;
  int    checks = 0;
  int    errors = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.validM = 0; s.inDslot = 0; s.adel = 0; s.ades = 0;
    s.sys = 0; s.brk = 0; s.eret = 0; s.ri = 0; s.ov = 0; s.we = 0;
    s.pcM = 32'hBFC0_0000; s.dataAddr = 0; s.wdata = 0;
    s.intI = 0; s.waddr = 0; s.raddr = 0;
    return s;
  endfunction

  function automatic logic [7:0] ipOf(stim_t s);
    return {mTimer | s.intI[5], s.intI[4:0], mCause[9:8]};
  endfunction

  function automatic int pickExc(stim_t s);
    bit pend;
    bit conds[9];
    pend  = ((ipOf(s) & mStatus[15:8]) != 8'h0) && mStatus[0] && !mStatus[1];
    conds = '{pend, (s.pcM[1:0] != 2'b00), s.ri, s.sys, s.brk, s.ov, s.adel, s.ades, s.eret};
    if (!s.validM) return -1;
    for (int i = 0; i < 9; i++)
      if (conds[i]) return i;
    return -1;
  endfunction

  function automatic exp_t expOf(stim_t s);
    exp_t e;
    int   idx;
    idx     = pickExc(s);
    e.exc   = (idx < 0) ? 32'h0 : 32'(excEnc[idx]);
    e.flush = (idx >= 0);
    if (idx == 8)
      e.newpc = (s.we && s.waddr == 5'd14) ? s.wdata : mEpc;
    else if (idx >= 0)
      e.newpc = VEC;
    else
      e.newpc = 32'h0;
    case (s.raddr)
      5'd8:    e.rdata = mBad;
      5'd9:    e.rdata = mCount;
      5'd11:   e.rdata = mCompare;
      5'd12:   e.rdata = mStatus;
      5'd13:   e.rdata = mCause;
      5'd14:   e.rdata = mEpc;
      5'd15:   e.rdata = PRID;
      default: e.rdata = 32'h0;
    endcase
    e.epc    = mEpc;
    e.status = mStatus;
    e.cause  = mCause;
    e.timer  = mTimer;
    return e;
  endfunction

  task automatic advance(stim_t s);
    logic [31:0] nCount, nCompare, nStatus, nCause, nEpc, nBad;
    logic        nTimer, nTick, wrOk;
    logic [7:0]  ip;
    int          idx;
    if (s.rst) begin
      mBad = 0; mCount = 0; mCompare = 0; mStatus = 32'h0040_0000;
      mCause = 0; mEpc = 0; mTimer = 0; mTick = 0;
      return;
    end
    idx      = pickExc(s);
    ip       = ipOf(s);
    nCount   = mTick ? mCount + 1 : mCount;
    nTick    = !mTick;
    nTimer   = mTimer || (mCount == mCompare && mCompare != 0);
    nCompare = mCompare;
    nStatus  = mStatus;
    nCause   = mCause;
    nEpc     = mEpc;
    nBad     = mBad;
    nCause[15:10] = ip[7:2];
    if (idx >= 0 && idx != 8) begin
      nStatus[1]  = 1'b1;
      nCause[6:2] = 5'(excCode[idx]);
      nCause[31]  = s.inDslot;
      nEpc        = s.inDslot ? s.pcM - 4 : s.pcM;
      if (idx == 1) nBad = s.pcM;
      if (idx == 6 || idx == 7) nBad = s.dataAddr;
    end
    if (idx == 8) nStatus[1] = 1'b0;
    wrOk = s.we && (idx < 0 || (idx == 8 && s.waddr == 5'd14));
    if (wrOk) begin
      case (s.waddr)
        5'd9:  begin nCount = s.wdata; nTick = 0; end
        5'd11: begin nCompare = s.wdata; nTimer = 0; end
        5'd12: begin nStatus[15:8] = s.wdata[15:8]; nStatus[1:0] = s.wdata[1:0]; end
        5'd13: nCause[9:8] = s.wdata[9:8];
        5'd14: nEpc = s.wdata;
        default: ;
      endcase
    end
    mCount = nCount; mTick = nTick; mTimer = nTimer; mCompare = nCompare;
    mStatus = nStatus; mCause = nCause; mEpc = nEpc; mBad = nBad;
  endtask

  task automatic apply(stim_t s);
    rst            = s.rst;
    bus.validM     = s.validM;
    bus.pcM        = s.pcM;
    bus.in_dslotM  = s.inDslot;
    bus.adelM      = s.adel;
    bus.adesM      = s.ades;
    bus.data_addrM = s.dataAddr;
    bus.syscallM   = s.sys;
    bus.breakM     = s.brk;
    bus.eretM      = s.eret;
    bus.riM        = s.ri;
    bus.ovM        = s.ov;
    bus.int_i      = s.intI;
    bus.we_i       = s.we;
    bus.waddr_i    = s.waddr;
    bus.wdata_i    = s.wdata;
    bus.raddr_i    = s.raddr;
  endtask

  task automatic step(stim_t s);
    @(posedge clk);
    advance(cur);
    #1;
    cur = s;
    apply(s);
    expQ.push_back(expOf(s));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("excepttype", bus.excepttype_o, e.exc);
      chk("flush", 32'(bus.flush_o), 32'(e.flush));
      chk("newpc", bus.newpc_o, e.newpc);
      chk("rdata", bus.rdata_o, e.rdata);
      chk("epc", bus.epc_o, e.epc);
      chk("status", bus.status_o, e.status);
      chk("cause", bus.cause_o, e.cause);
      chk("timer_int", 32'(bus.timer_int_o), 32'(e.timer));
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    logic [31:0] r;
    s = idle();
    s.rst      = ($urandom_range(0, 99) == 0);
    s.validM   = ($urandom_range(0, 9) != 0);
    r          = $urandom();
    if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
    s.pcM      = r;
    s.inDslot  = 1'($urandom_range(0, 1));
    s.adel     = ($urandom_range(0, 9) == 0);
    s.ades     = ($urandom_range(0, 9) == 0);
    s.sys      = ($urandom_range(0, 15) == 0);
    s.brk      = ($urandom_range(0, 15) == 0);
    s.eret     = ($urandom_range(0, 7) == 0);
    s.ri       = ($urandom_range(0, 15) == 0);
    s.ov       = ($urandom_range(0, 15) == 0);
    s.dataAddr = $urandom();
    s.intI     = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'h0;
    s.we       = ($urandom_range(0, 2) == 0);
    s.waddr    = 5'(wTab[$urandom_range(0, 7)]);
    s.wdata    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
    s.raddr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(wTab[$urandom_range(0, 7)]);
    return s;
  endfunction

  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1;
    apply(cur);
    advance(cur);

    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rst = 1; s.raddr = 5'd12; step(s);
    end

    // AdEL, not in a delay slot
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0100; s.adel = 1;
    s.dataAddr = 32'h8000_0003; s.raddr = 5'd8; step(s);
    s = idle(); s.raddr = 5'd8;  step(s);
    s.raddr = 5'd14; step(s);
    s.raddr = 5'd13; step(s);

    // AdES in a delay slot
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0208; s.inDslot = 1; s.ades = 1;
    s.dataAddr = 32'h0000_1001; step(s);
    s = idle(); s.raddr = 5'd14; step(s);

    // RI beats OV and AdES; BadVAddr must not move
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0010; s.ri = 1; s.ov = 1; s.ades = 1;
    s.dataAddr = 32'hDEAD_0000; step(s);
    s = idle(); s.raddr = 5'd8; step(s);

    // Fetch misalignment records pcM in BadVAddr
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0402; s.adel = 1; s.dataAddr = 32'h55; step(s);
    s = idle(); s.raddr = 5'd8; step(s);

    // Timer interrupt: IM7+IE, Count=0, Compare=10
    s = idle(); s.we = 1; s.waddr = 5'd12; s.wdata = 32'h0000_8001; step(s);
    s = idle(); s.we = 1; s.waddr = 5'd9;  s.wdata = 32'h0; step(s);
    s = idle(); s.we = 1; s.waddr = 5'd11; s.wdata = 32'd10; s.raddr = 5'd11; step(s);
    for (int i = 0; i < 28; i++) begin
      s = idle(); s.raddr = 5'd9; s.adel = 1; step(s);
    end
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0500; step(s);
    s = idle(); s.we = 1; s.waddr = 5'd11; s.wdata = 32'h0; step(s);
    s = idle(); s.raddr = 5'd13; step(s);

    // ERET from EPC, then ERET with EPC bypass
    s = idle(); s.we = 1; s.waddr = 5'd14; s.wdata = 32'hBFC0_0300; step(s);
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0600; s.eret = 1; step(s);
    s = idle(); s.raddr = 5'd12; step(s);
    s = idle(); s.validM = 1; s.pcM = 32'hBFC0_0604; s.eret = 1;
    s.we = 1; s.waddr = 5'd14; s.wdata = 32'h0000_1234; step(s);
    s = idle(); s.raddr = 5'd14; step(s);

    // Exception drops a same-cycle MTC0
    s = idle(); s.validM = 1; s.sys = 1; s.we = 1; s.waddr = 5'd14; s.wdata = 32'h7777_0000; step(s);
    s = idle(); s.raddr = 5'd14; step(s);

    // Count wrap
    s = idle(); s.we = 1; s.waddr = 5'd9; s.wdata = 32'hFFFF_FFFF; step(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.raddr = 5'd9; step(s);
    end

    // Bubble ignores exception flags
    s = idle(); s.adel = 1; s.sys = 1; s.pcM = 32'hBFC0_0701; step(s);
    s = idle(); s.raddr = 5'd8; step(s);

    // Reset during an exception
    s = idle(); s.rst = 1; s.validM = 1; s.sys = 1; step(s);
    s = idle(); s.raddr = 5'd12; step(s);

    for (int i = 0; i < 3000; i++) step(rnd());

    step(idle());
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Memory-stage exception collector and CP0 register file for the MIPS core. It is fed by the memory-stage address-alignment checker (adelM/adesM) and by decode/execute exception flags carried down the pipeline. It prioritises all exceptions, updates BadVAddr/Count/Compare/Status/Cause/EPC, and drives the pipeline flush and redirect PC.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for every exception except ERET
PRID_VAL, 32'h004C0102, read-only PRId (reg 15) value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
validM  in  1  memory-stage slot holds a real instruction (0 = bubble)
pcM  in  32  memory-stage PC
in_dslotM  in  1  memory-stage instruction is in a branch delay slot
adelM  in  1  data-load address error
adesM  in  1  data-store address error
data_addrM  in  32  faulting data address
syscallM, breakM, eretM, riM, ovM  in  1 each  syscall, break, eret, reserved-instr, overflow
int_i  in  6  external hardware interrupts, mapped to IP[7:2]
we_i  in  1  MTC0 write enable (memory stage)
waddr_i  in  5  MTC0 register number
wdata_i  in  32  MTC0 data
raddr_i  in  5  MFC0 register number
rdata_o  out  32  MFC0 read data (combinational)
excepttype_o  out  32  encoded exception, 0 = none
flush_o  out  1  flush all stages up to memory
newpc_o  out  32  redirect target
epc_o, status_o, cause_o  out  32 each  current register values
timer_int_o  out  1  Count==Compare pending

Behaviour:
- Reset: BadVAddr=0, Count=0, Compare=0, Status=32'h0040_0000 (BEV=1, EXL=0, IE=0), Cause=0, EPC=0, timer_int_o=0, Count-tick toggle=0. Combinational outputs follow the reset state: excepttype_o=0, flush_o=0, newpc_o=0.
- Interrupt pending: IP = {timer_int_o | int_i[5], int_i[4:0], Cause[9:8]}. int_pend = |(IP & Status[15:8]) & Status[0] & ~Status[1].
- Cause[15:10] are sampled from IP every cycle.
- Exception priority (highest first, evaluated only when validM=1):
  - int_pend: 0x1
  - fetch misalignment (pcM[1:0]!=0): 0x4
  - riM: 0xa
  - syscallM: 0x8
  - breakM: 0x9
  - ovM: 0xc
  - adelM: 0x4
  - adesM: 0x5
  - eretM: 0xe
- excepttype_o, flush_o and newpc_o are combinational, zero-latency.
- flush_o = (excepttype_o != 0).
- newpc_o: EXC_VECTOR for any exception; EPC for 0xe. If we_i is set with waddr_i=14 in the ERET cycle, newpc_o = wdata_i (bypass).
- On a taken exception other than ERET, at the next clk edge:
  - Status[1] (EXL) <= 1
  - Cause[6:2] <= ExcCode: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12
  - Cause[31] (BD) <= in_dslotM
  - EPC <= pcM-4 if in_dslotM, else pcM
- BadVAddr update: pcM for fetch misalignment; data_addrM for adelM/adesM; unchanged for all other codes.
- ERET: Status[1] <= 0 at the next edge; no other register changes.
- Exception and MTC0 in the same cycle: the exception wins and the write is dropped. The exception-free ERET-with-EPC-bypass case is the only same-cycle write honoured.
- MTC0 writable fields:
  - BadVAddr (8): read-only
  - Count (9): full 32 bits
  - Compare (11): full 32 bits; also clears timer_int_o
  - Status (12): bits [15:8], [1], [0] only
  - Cause (13): bits [9:8] only
  - EPC (14): full 32 bits
  - Writes to other numbers are ignored.
- Count increments by 1 every second clk via a tick toggle and wraps at 0xFFFFFFFF to 0.
- An MTC0 write to Count overrides the increment in that cycle and resets the tick toggle.
- timer_int_o is set when Count==Compare and Compare!=0, and holds until Compare is written. Set and clear in the same cycle: clear wins.
- rdata_o: combinational mux on raddr_i. PRId returns PRID_VAL; unmapped numbers return 0. No internal write-to-read bypass.
- validM=0: all exception inputs are ignored and excepttype_o=0. Interrupts wait for a valid slot.
- rst asserted mid-exception: reset values win on that edge.

Test Plan:
- Load with adelM=1, data_addrM=32'h8000_0003, pcM=32'hBFC0_0100, in_dslotM=0 -> excepttype_o=0x4, flush_o=1, newpc_o=32'hBFC00380. Next cycle: EPC=32'hBFC0_0100, BadVAddr=32'h8000_0003, Cause[6:2]=4, Status[1]=1.
- adesM=1 with in_dslotM=1, pcM=32'hBFC0_0208 -> EPC=32'hBFC0_0204, Cause[31]=1, Cause[6:2]=5.
- riM=1 and ovM=1 together with adesM=1 -> excepttype_o=0xa; BadVAddr unchanged.
- Write Status=32'h0000_8001, then Compare=10; after Count reaches 10 -> timer_int_o=1, next valid slot gives excepttype_o=0x1. Writing Compare clears timer_int_o.
- ERET with EPC=32'hBFC0_0300 -> newpc_o=32'hBFC0_0300, Status[1] cleared next cycle. The same ERET with MTC0 EPC=32'h1234 in that cycle -> newpc_o=32'h1234.
- validM=0 with adelM=1, syscallM=1 -> excepttype_o=0, flush_o=0, no register change. Reset asserted during an exception -> Status=32'h0040_0000.
